word_packer: RTL and testbench
==============================

Name: word_packer

Overview:
- Parametrised lane packer. It gathers LANES consecutive DATA_W-bit samples from a valid/ready input stream into one LANES*DATA_W-bit word.
- It is the next generation of the fixed 4x8-bit button-counter concatenator.
- It adds input/output handshakes, selectable lane order, partial-word flush and back-pressure.
- It sits between per-event counters and the memory-driver write path.

Parameters:
- DATA_W, 8, width of one input sample (lane); >=1
- LANES, 4, samples per packed word; >=2
- MSB_FIRST, 1, 1: first sample lands in the top lane; 0: first sample lands in bits [DATA_W-1:0]

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- in_data  input  DATA_W  input sample
- in_valid  input  1  in_data valid
- in_ready  output  1  packer can accept in_data this cycle
- flush  input  1  one-cycle request to emit the current partial word
- out_data  output  LANES*DATA_W  packed word
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- out_count  output  clog2(LANES+1)  number of valid lanes in out_data (LANES for a full word)
- busy  output  1  accumulator holds >=1 sample or a flush is pending

Behaviour:
- Reset (rst=0, async):
  - out_data=0, out_valid=0, out_count=0, busy=0.
  - Accumulator lanes and lane counter cnt=0; flush_pend=0.
  - in_ready rises on the first clk edge after rst releases; it stays 0 while rst=0.
  - Reset mid-word discards the partial word with no output.
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - slot_free = !out_valid | out_ready.
- Accumulate:
  - On in_fire, in_data is written to lane index cnt, and cnt increments.
  - Lane k occupies bits [(LANES-1-k)*DATA_W +: DATA_W] when MSB_FIRST=1, and bits [k*DATA_W +: DATA_W] when MSB_FIRST=0.
- Full word:
  - On in_fire with cnt==LANES-1, the completed word (including this sample) loads the output register on the same edge. out_valid=1 and out_count=LANES in the following cycle.
  - cnt wraps to 0 and the accumulator lanes clear to 0.
  - Latency: the last sample's edge to out_valid is 1 cycle.
- Back-pressure: in_ready = !(cnt==LANES-1 & !slot_free) & !(flush_pend & !slot_free). Accepting non-final samples never stalls, even while the output is held.
- Output hold:
  - out_data, out_count and out_valid stay stable while out_valid=1 & out_ready=0.
  - out_fire with no new load drops out_valid=0 on the next cycle. out_data keeps its old value.
  - out_fire together with a new load gives back-to-back words with no bubble.
- Flush:
  - A flush pulse sets flush_pend when cnt>0, or when an in_fire occurs in the same cycle.
  - A flush with cnt==0 and no in_fire is ignored.
  - A pending flush executes on the first edge with slot_free. The partial word (cnt lanes) loads the output, out_count=cnt, unused lanes are 0, then cnt=0 and flush_pend=0.
  - Flush coincident with in_fire: the sample is accepted first, then the flush covers it.
  - If that sample completes the word, the result is a normal full word and flush_pend is cleared (no empty word is emitted).
- busy = (cnt!=0) | flush_pend.
- Widths: cnt is clog2(LANES) bits. It wraps only via the full-word or flush paths and never reaches LANES.

Test Plan:
- Reset then feed 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=1 (defaults) -> one cycle after 0x44: out_data=0x11223344, out_valid=1 for 1 cycle, out_count=4.
- Same stimulus with MSB_FIRST=0 -> out_data=0x44332211.
- Hold out_ready=0 and stream 8 samples 0x01..0x08 -> first word 0x01020304 held stable. in_ready=0 only when 0x08 is presented. Raise out_ready -> 0x05060708 follows with no bubble. No sample is lost or duplicated.
- Feed 0xAA,0xBB then a flush pulse -> out_data=0xAABB0000, out_count=2, busy=0 afterwards. A flush with empty accumulator produces no output.
- Feed 0x10,0x20,0x30, then present 0x40 with flush in the same cycle -> a single word 0x10203040 with out_count=4, and no extra empty word.
- Feed 0x01,0x02, assert rst=0 for 1 cycle asynchronously mid-cycle -> outputs zero immediately. Then feed 0x0A..0x0D -> out_data=0x0A0B0C0D (no stale lanes).

Source files
------------

// File: rtl/word_packer.sv
// Lane packer: gathers LANES consecutive DATA_W-bit samples from a valid/ready stream into one
// packed word, with selectable lane order, partial-word flush and output back-pressure.
module word_packer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LANES     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [DATA_W-1:0]            in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         flush_i,
  output logic [LANES*DATA_W-1:0]      out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [$clog2(LANES+1)-1:0]   out_count_o,
  output logic                         busy_o
);

  localparam int unsigned WordW  = LANES * DATA_W;
  localparam int unsigned CntW   = $clog2(LANES);
  localparam int unsigned CountW = $clog2(LANES + 1);

  localparam logic [CntW-1:0]   LastIdx   = CntW'(LANES - 1);
  localparam logic [CountW-1:0] FullCount = CountW'(LANES);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("word_packer: DATA_W must be at least 1");
  end
  if (LANES < 2) begin : g_bad_lanes
    $error("word_packer: LANES must be at least 2");
  end

  // Bit offset of lane k inside the packed word.
  function automatic int unsigned lane_lsb(input int unsigned k);
    if (MSB_FIRST) begin
      lane_lsb = (LANES - 1 - k) * DATA_W;
    end else begin
      lane_lsb = k * DATA_W;
    end
  endfunction

  logic [WordW-1:0]  acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic [WordW-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [CountW-1:0] out_count_q, out_count_d;
  logic              live_q;

  logic              slot_free;
  logic              in_fire;
  logic              word_done;
  logic              flush_take;
  logic              flush_exec;
  logic [WordW-1:0]  acc_upd;
  logic [CntW-1:0]   cnt_upd;
  logic [CountW-1:0] fill_upd;

  assign slot_free  = ~out_valid_q | out_ready_i;
  // live_q keeps in_ready low until the first edge after reset release.
  assign in_ready_o = live_q
                    & ~((cnt_q == LastIdx) & ~slot_free)
                    & ~(flush_pend_q & ~slot_free);
  assign in_fire    = in_valid_i & in_ready_o;
  assign word_done  = in_fire & (cnt_q == LastIdx);
  assign flush_take = flush_i & ((cnt_q != '0) | in_fire);
  assign flush_exec = flush_pend_q & slot_free;

  always_comb begin
    acc_upd = acc_q;
    if (in_fire) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (cnt_q == CntW'(k)) begin
          acc_upd[lane_lsb(k) +: DATA_W] = in_data_i;
        end
      end
    end
  end

  assign cnt_upd  = cnt_q + CntW'(in_fire);
  assign fill_upd = CountW'(cnt_q) + CountW'(in_fire);

  always_comb begin
    acc_d        = acc_upd;
    cnt_d        = cnt_upd;
    flush_pend_d = flush_pend_q | flush_take;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_valid_d  = out_valid_q & ~out_ready_i;

    if (word_done) begin
      // A completed word absorbs any flush request; no empty word follows.
      out_data_d   = acc_upd;
      out_count_d  = FullCount;
      out_valid_d  = 1'b1;
      acc_d        = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end else if (flush_exec) begin
      out_data_d   = acc_upd;
      out_count_d  = fill_upd;
      out_valid_d  = 1'b1;
      acc_d        = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_count_q  <= '0;
      live_q       <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_count_q  <= out_count_d;
      live_q       <= 1'b1;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_count_o = out_count_q;
  assign busy_o      = (cnt_q != '0) | flush_pend_q;

endmodule

// File: tb/tb_word_packer.sv
// Bench for word_packer: both lane orders driven in parallel and compared every cycle against a
// queue-based model of the packing rules, plus directed checks with literal expected words.
module tb_word_packer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned WordW  = DATA_W * LANES;
  localparam int unsigned CountW = $clog2(LANES + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              flush;
  logic              out_ready;

  logic              rdy_m, ov_m, busy_m;
  logic [WordW-1:0]  od_m;
  logic [CountW-1:0] oc_m;
  logic              rdy_l, ov_l, busy_l;
  logic [WordW-1:0]  od_l;
  logic [CountW-1:0] oc_l;

  always #5 clk = ~clk;

  word_packer #(.DATA_W(DATA_W), .LANES(LANES), .MSB_FIRST(1'b1)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(rdy_m), .flush_i(flush), .out_data_o(od_m), .out_valid_o(ov_m),
    .out_ready_i(out_ready), .out_count_o(oc_m), .busy_o(busy_m)
  );

  word_packer #(.DATA_W(DATA_W), .LANES(LANES), .MSB_FIRST(1'b0)) dut_l (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(rdy_l), .flush_i(flush), .out_data_o(od_l), .out_valid_o(ov_l),
    .out_ready_i(out_ready), .out_count_o(oc_l), .busy_o(busy_l)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: samples of the word being built, pending-flush flag, output register.
  int               q[$];
  bit               m_pend;
  bit               m_live;
  bit               m_ov;
  logic [WordW-1:0] m_od_m;
  logic [WordW-1:0] m_od_l;
  int               m_oc;

  function automatic logic [WordW-1:0] pack(input bit msb);
    logic [WordW-1:0] w = '0;
    for (int k = 0; k < q.size(); k++) begin
      if (msb) w[(LANES - 1 - k) * DATA_W +: DATA_W] = q[k][DATA_W-1:0];
      else     w[k * DATA_W +: DATA_W] = q[k][DATA_W-1:0];
    end
    return w;
  endfunction

  function automatic bit model_ready(input bit r);
    return m_live && !(((q.size() == LANES - 1) || m_pend) && m_ov && !r);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit er = model_ready(out_ready);
    bit eb = (q.size() > 0) || m_pend;
    chk("in_ready_m", 64'(rdy_m), 64'(er));
    chk("in_ready_l", 64'(rdy_l), 64'(er));
    chk("out_valid_m", 64'(ov_m), 64'(m_ov));
    chk("out_valid_l", 64'(ov_l), 64'(m_ov));
    chk("out_data_m", 64'(od_m), 64'(m_od_m));
    chk("out_data_l", 64'(od_l), 64'(m_od_l));
    chk("out_count_m", 64'(oc_m), 64'(m_oc));
    chk("out_count_l", 64'(oc_l), 64'(m_oc));
    chk("busy_m", 64'(busy_m), 64'(eb));
    chk("busy_l", 64'(busy_l), 64'(eb));
  endtask

  task automatic emit();
    m_od_m = pack(1'b1);
    m_od_l = pack(1'b0);
    m_oc   = q.size();
    m_ov   = 1'b1;
    q.delete();
    m_pend = 1'b0;
  endtask

  // Drive one cycle of inputs, check, advance the model across the edge.
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit f, input bit r);
    bit fire;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    #1;
    check_all();
    fire = v && model_ready(r);
    @(posedge clk);
    if (fire) q.push_back(int'(d));
    if (q.size() == LANES) begin
      emit();
    end else if (m_pend && (!m_ov || r)) begin
      emit();
    end else begin
      if (m_ov && r) m_ov = 1'b0;
      if (f && q.size() > 0) m_pend = 1'b1;
    end
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [WordW-1:0] em,
                             input logic [WordW-1:0] el, input int cnt);
    chk({tag, "_valid"}, 64'(ov_m), 64'(1));
    chk({tag, "_data_m"}, 64'(od_m), 64'(em));
    chk({tag, "_data_l"}, 64'(od_l), 64'(el));
    chk({tag, "_count"}, 64'(oc_m), 64'(cnt));
  endtask

  task automatic model_clear();
    q.delete();
    m_pend = 1'b0;
    m_live = 1'b0;
    m_ov   = 1'b0;
    m_od_m = '0;
    m_od_l = '0;
    m_oc   = 0;
  endtask

  task automatic mid_reset();
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check_all();
    @(posedge clk);
    #1;
    m_live = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    model_clear();
    #12;
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_live = 1'b1;

    // Basic full word, both lane orders.
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h44, 1'b0, 1'b1);
    expect_word("basic", 32'h11223344, 32'h44332211, 4);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("basic_one_cycle", 64'(ov_m), 64'(0));

    // Back-pressure: stall only on the word-completing sample.
    for (int i = 1; i <= 7; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h08, 1'b0, 1'b0);
    chk("bp_stall", 64'(rdy_m), 64'(0));
    expect_word("bp_hold", 32'h01020304, 32'h04030201, 4);
    step(1'b1, 8'h08, 1'b0, 1'b1);
    expect_word("bp_next", 32'h05060708, 32'h08070605, 4);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Partial-word flush, then a flush with an empty accumulator.
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    expect_word("flush", 32'hAABB0000, 32'h0000BBAA, 2);
    chk("flush_busy", 64'(busy_m), 64'(0));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("empty_flush", 64'(ov_m), 64'(0));

    // Flush coincident with the word-completing sample.
    step(1'b1, 8'h10, 1'b0, 1'b1);
    step(1'b1, 8'h20, 1'b0, 1'b1);
    step(1'b1, 8'h30, 1'b0, 1'b1);
    step(1'b1, 8'h40, 1'b1, 1'b1);
    expect_word("flush_full", 32'h10203040, 32'h40302010, 4);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("no_empty_word", 64'(ov_m), 64'(0));
    chk("no_empty_busy", 64'(busy_m), 64'(0));

    // Asynchronous reset mid-word discards the partial word.
    step(1'b1, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h02, 1'b0, 1'b1);
    mid_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h0A + i), 1'b0, 1'b1);
    expect_word("post_reset", 32'h0A0B0C0D, 32'h0D0C0B0A, 4);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(9) < 7), 8'($urandom), ($urandom_range(7) == 0),
           ($urandom_range(9) < 6));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
